// File: rtl/trng_pkg.sv
// trng_pkg: shared state encoding and default parameters for the TRNG conditioner
package trng_pkg;
   typedef enum logic [1:0] {COLLECT, READY, DELIVER, FAULT} trng_state_t;
   localparam int TRNG_WIDTH_DEF = 8;
   localparam int RCT_LIMIT_DEF = 32;
endpackage

// File: rtl/trng_conditioner_if.sv
// trng_conditioner_if: raw entropy input and word-delivery handshake of the conditioner
interface trng_conditioner_if #(parameter int W = 8) ();
   logic raw_bit;
   logic raw_valid;
   logic trng_req;
   logic [W-1:0] trng_word;
   logic trng_valid;
   logic fault;
   modport master (input raw_bit, raw_valid, trng_req, output trng_word, trng_valid, fault);
   modport slave (output raw_bit, raw_valid, trng_req, input trng_word, trng_valid, fault);
endinterface

// File: rtl/trng_vn_debias.sv
// trng_vn_debias: von Neumann debiaser, pair 10 -> 1, 01 -> 0, 00/11 discarded
module trng_vn_debias (
   input  logic clk,
   input  logic resetn,
   input  logic raw_bit,
   input  logic raw_valid,
   output logic db_bit,
   output logic db_valid
);
   logic phase_q, phase_d, first_q, first_d, db_bit_q, db_bit_d, db_valid_q, db_valid_d;
   always_comb begin
      phase_d = raw_valid ? ~phase_q : phase_q;
      first_d = raw_valid && !phase_q ? raw_bit : first_q;
      db_valid_d = raw_valid && phase_q && first_q != raw_bit;
      db_bit_d = first_q;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         phase_q <= 1'b0;
         first_q <= 1'b0;
         db_bit_q <= 1'b0;
         db_valid_q <= 1'b0;
      end else begin
         phase_q <= phase_d;
         first_q <= first_d;
         db_bit_q <= db_bit_d;
         db_valid_q <= db_valid_d;
      end
   end
   assign db_bit = db_bit_q;
   assign db_valid = db_valid_q;
endmodule

// File: rtl/trng_conditioner.sv
// trng_conditioner: debiased word assembly, one-word hold, request-driven delivery and sticky RCT fault
module trng_conditioner
   import trng_pkg::*;
#(
   parameter int TRNG_WIDTH = TRNG_WIDTH_DEF,
   parameter int RCT_LIMIT = RCT_LIMIT_DEF
) (
   input logic clk,
   input logic resetn,
   trng_conditioner_if.master bus
);
   localparam int CW = $clog2(TRNG_WIDTH + 1);
   trng_state_t state_q, state_d;
   logic [TRNG_WIDTH-1:0] asm_q, asm_d, hold_q, hold_d, word_q, word_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [7:0] run_q, run_d;
   logic last_q, last_d, fault_q, fault_d, valid_q, valid_d;
   logic db_bit, db_valid, same, trip, load, full;
   trng_vn_debias u_debias (
      .clk(clk),
      .resetn(resetn),
      .raw_bit(bus.raw_bit),
      .raw_valid(bus.raw_valid),
      .db_bit(db_bit),
      .db_valid(db_valid)
   );
   always_comb begin
      same = run_q != 8'd0 && bus.raw_bit == last_q;
      run_d = !bus.raw_valid ? run_q : !same ? 8'd1 : run_q == 8'hFF ? run_q : run_q + 8'd1;
      last_d = bus.raw_valid ? bus.raw_bit : last_q;
      trip = bus.raw_valid && run_d == 8'(RCT_LIMIT);
      fault_d = fault_q | trip;
      full = cnt_q == CW'(TRNG_WIDTH);
      // hold is empty in COLLECT and DELIVER; a bit arriving on the load edge starts the next word
      load = full && (state_q == COLLECT || state_q == DELIVER);
      hold_d = load ? asm_q : hold_q;
      asm_d = db_valid && (load || !full) ? {db_bit, asm_q[TRNG_WIDTH-1:1]} : asm_q;
      cnt_d = fault_d ? '0 : load ? CW'(db_valid) : db_valid && !full ? cnt_q + CW'(1) : cnt_q;
      valid_d = state_q == READY && bus.trng_req && !trip;
      word_d = valid_d ? hold_q : '0;
      state_d = fault_d ? FAULT
              : state_q == READY ? (bus.trng_req ? DELIVER : READY)
              : load ? READY
              : state_q == DELIVER ? COLLECT : state_q;
   end
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= COLLECT;
         asm_q <= '0;
         cnt_q <= '0;
         hold_q <= '0;
         run_q <= '0;
         last_q <= 1'b0;
         fault_q <= 1'b0;
         valid_q <= 1'b0;
         word_q <= '0;
      end else begin
         state_q <= state_d;
         asm_q <= asm_d;
         cnt_q <= cnt_d;
         hold_q <= hold_d;
         run_q <= run_d;
         last_q <= last_d;
         fault_q <= fault_d;
         valid_q <= valid_d;
         word_q <= word_d;
      end
   end
   assign bus.trng_word = word_q;
   assign bus.trng_valid = valid_q;
   assign bus.fault = fault_q;
endmodule

// File: tb/tb_trng_conditioner.sv
// tb_trng_conditioner: directed vectors and corner sequences for trng_conditioner
module tb_trng_conditioner;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;
   trng_conditioner_if #(.W(8)) bus ();
   trng_conditioner #(.TRNG_WIDTH(8), .RCT_LIMIT(32)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   typedef struct {
      logic [31:0] raw;
      int np;
      logic [7:0] exp;
   } vec_t;
   vec_t vecs[7];
   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] words[$];
   logic prev_v = 1'b0;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send(input logic b);
      bus.raw_valid = 1'b1;
      bus.raw_bit = b;
      tick();
      bus.raw_valid = 1'b0;
   endtask
   task automatic send_word(input logic [7:0] w);
      for (int i = 0; i < 8; i++) begin
         send(w[i]);
         send(!w[i]);
      end
   endtask
   task automatic idle(input int n);
      repeat (n) tick();
   endtask
   task automatic do_reset();
      bus.trng_req = 1'b0;
      bus.raw_valid = 1'b0;
      bus.raw_bit = 1'b0;
      resetn = 1'b0;
      tick();
      resetn = 1'b1;
      words.delete();
   endtask
   function automatic logic [31:0] word_at(input int i);
      return words.size() > i ? {24'd0, words[i]} : 32'hDEAD;
   endfunction
   always @(negedge clk) begin
      if (bus.trng_valid) begin
         words.push_back(bus.trng_word);
         n_cmp++;
         if (prev_v || bus.fault) begin
            n_bad++;
            $display("FAIL pulse_spacing: prev_valid=%0b fault=%0b, required 0 0", prev_v, bus.fault);
         end
      end
      prev_v = bus.trng_valid;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      vecs[0] = '{32'b10_01_10_10_01_01_10_01_0000000000000000, 8, 8'h4D};
      vecs[1] = '{32'b10_00_01_11_10_10_00_01_01_11_10_01_00000000, 12, 8'h4D};
      vecs[2] = '{32'b10_10_10_10_10_10_10_10_0000000000000000, 8, 8'hFF};
      vecs[3] = '{32'b01_01_01_01_01_01_01_01_0000000000000000, 8, 8'h00};
      vecs[4] = '{32'b01_10_01_10_01_10_01_10_0000000000000000, 8, 8'hAA};
      vecs[5] = '{32'b10_10_10_10_01_01_01_01_0000000000000000, 8, 8'h0F};
      vecs[6] = '{32'b01_01_01_10_11_00_10_01_01_10_000000000000, 10, 8'h98};
      bus.trng_req = 1'b0;
      bus.raw_valid = 1'b0;
      bus.raw_bit = 1'b0;
      idle(2);
      chk("reset_word", {24'd0, bus.trng_word}, 32'd0);
      chk("reset_valid", {31'd0, bus.trng_valid}, 32'd0);
      chk("reset_fault", {31'd0, bus.fault}, 32'd0);
      for (int v = 0; v < 7; v++) begin
         do_reset();
         bus.trng_req = 1'b1;
         for (int j = 0; j < 2 * vecs[v].np; j++) send(vecs[v].raw[31-j]);
         idle(8);
         chk($sformatf("vec%0d_count", v), words.size(), 32'd1);
         chk($sformatf("vec%0d_word", v), word_at(0), {24'd0, vecs[v].exp});
         chk($sformatf("vec%0d_fault", v), {31'd0, bus.fault}, 32'd0);
      end
      // retention: two words held, third dropped, then request held
      do_reset();
      send_word(8'h4D);
      send_word(8'h0F);
      send_word(8'hFF);
      idle(6);
      chk("retain_no_pulse", words.size(), 32'd0);
      bus.trng_req = 1'b1;
      tick();
      chk("retain_valid1", {31'd0, bus.trng_valid}, 32'd1);
      chk("retain_word1", {24'd0, bus.trng_word}, 32'h4D);
      tick();
      chk("retain_gap", {31'd0, bus.trng_valid}, 32'd0);
      tick();
      chk("retain_valid2", {31'd0, bus.trng_valid}, 32'd1);
      chk("retain_word2", {24'd0, bus.trng_word}, 32'h0F);
      idle(20);
      chk("retain_total", words.size(), 32'd2);
      // RCT trip coinciding with a pending delivery
      do_reset();
      send_word(8'hAA);
      idle(5);
      repeat (31) send(1'b1);
      chk("rct31_fault", {31'd0, bus.fault}, 32'd0);
      bus.trng_req = 1'b1;
      send(1'b1);
      chk("rct32_fault", {31'd0, bus.fault}, 32'd1);
      chk("rct32_valid", {31'd0, bus.trng_valid}, 32'd0);
      for (int i = 0; i < 10; i++) begin
         send(1'b1);
         send(1'b0);
      end
      idle(5);
      chk("fault_no_pulse", words.size(), 32'd0);
      chk("fault_word", {24'd0, bus.trng_word}, 32'd0);
      chk("fault_sticky", {31'd0, bus.fault}, 32'd1);
      // 31 repeats then a change never trips
      do_reset();
      repeat (31) send(1'b1);
      send(1'b0);
      idle(3);
      chk("rct_no_trip", {31'd0, bus.fault}, 32'd0);
      // reset with 5 bits assembled, fault set and pair phase mid-pair
      do_reset();
      repeat (5) begin
         send(1'b1);
         send(1'b0);
      end
      repeat (33) send(1'b1);
      chk("pre_reset_fault", {31'd0, bus.fault}, 32'd1);
      resetn = 1'b0;
      tick();
      chk("midreset_word", {24'd0, bus.trng_word}, 32'd0);
      chk("midreset_valid", {31'd0, bus.trng_valid}, 32'd0);
      chk("midreset_fault", {31'd0, bus.fault}, 32'd0);
      resetn = 1'b1;
      words.delete();
      bus.trng_req = 1'b1;
      repeat (3) begin
         send(1'b0);
         send(1'b1);
      end
      idle(6);
      chk("fresh_partial", words.size(), 32'd0);
      repeat (5) begin
         send(1'b1);
         send(1'b0);
      end
      idle(8);
      chk("fresh_count", words.size(), 32'd1);
      chk("fresh_word", word_at(0), 32'hF8);
      // back-to-back words with request held
      do_reset();
      bus.trng_req = 1'b1;
      send_word(8'h4D);
      send_word(8'hC3);
      send_word(8'h5A);
      idle(10);
      chk("b2b_count", words.size(), 32'd3);
      chk("b2b_word0", word_at(0), 32'h4D);
      chk("b2b_word1", word_at(1), 32'hC3);
      chk("b2b_word2", word_at(2), 32'h5A);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
